// File: rtl/t_timer_pkg.sv
// t_timer_pkg
//    Shared definitions for the session countdown timer:
//    - state_t      : FSM state encoding, also exported on the debug port
//    - TW_DEFAULT   : default width of T and of the minute counters
//    - tick_width() : prescaler width needed for a given ticks-per-minute
package t_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADED = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int TW_DEFAULT = 9;

   // Width of a counter that holds 0..ticks-1. Never returns less than 1 so
   // the prescaler stays a legal vector for the smallest legal tick count.
   function automatic int tick_width(input int ticks);
      return (ticks < 2) ? 1 : $clog2(ticks);
   endfunction

endpackage

// File: rtl/t_timer_tick_gen.sv
// tick_gen
//    Minute prescaler. Counts 0..TICKS_PER_UNIT-1 while enabled and wraps;
//    tick is high during the last count of each minute.
//    Ports:
//       clk   in   system clock
//       rstn  in   asynchronous active-low reset
//       clr   in   force the count to 0 on the next edge (start of a session)
//       en    in   advance the count this cycle (timer running)
//       tick  out  one minute has elapsed at the end of this cycle
module tick_gen
   import t_timer_pkg::*;
#(
   parameter int TICKS_PER_UNIT = 50
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = tick_width(TICKS_PER_UNIT);
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_UNIT - 1);

   logic [PW-1:0] count_reg;
   logic [PW-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en) begin
         count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Combinational so the minute counters update on the same edge that
   // wraps the prescaler.
   assign tick = en & (count_reg == LAST);

endmodule

// File: rtl/t_timer.sv
// t_timer
//    Session countdown timer. Accepts a training time T (minutes) over a
//    valid/ready handshake and counts it down in real time with
//    start / pause / resume / abort control.
//    Ports:
//       clk        in   system clock
//       rstn       in   asynchronous active-low reset
//       t_in       in   training time in minutes
//       t_valid    in   t_in valid this cycle
//       t_ready    out  a new T can be accepted (IDLE, LOADED, DONE)
//       start      in   level: start a loaded session / resume a paused one
//       pause      in   level: pause a running session
//       abort      in   level: cancel any session
//       remaining  out  minutes left
//       elapsed    out  minutes completed in this session
//       busy       out  high in RUN or PAUSE
//       paused     out  high in PAUSE
//       done       out  one-cycle pulse on session completion
//       state      out  current FSM state encoding
module t_timer
   import t_timer_pkg::*;
#(
   parameter int TICKS_PER_UNIT = 50,
   parameter int TW             = TW_DEFAULT
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [TW-1:0] t_in,
   input  logic          t_valid,
   output logic          t_ready,
   input  logic          start,
   input  logic          pause,
   input  logic          abort,
   output logic [TW-1:0] remaining,
   output logic [TW-1:0] elapsed,
   output logic          busy,
   output logic          paused,
   output logic          done,
   output logic [2:0]    state
);

   state_t        state_reg, state_next;
   logic [TW-1:0] remaining_reg, remaining_next;
   logic [TW-1:0] elapsed_reg, elapsed_next;
   logic          done_reg, done_next;
   logic          busy_reg, busy_next;
   logic          paused_reg, paused_next;

   logic          load;
   logic          load_zero;
   logic          done_evt;
   logic          presc_clr;
   logic          presc_en;
   logic          tick;

   // ---------------------------------------------------------------------
   // Minute prescaler
   // ---------------------------------------------------------------------
   assign presc_en = (state_reg == ST_RUN);

   tick_gen #(
      .TICKS_PER_UNIT (TICKS_PER_UNIT)
   ) u_tick_gen (
      .clk  (clk),
      .rstn (rstn),
      .clr  (presc_clr),
      .en   (presc_en),
      .tick (tick)
   );

   // ---------------------------------------------------------------------
   // Handshake: ready depends on state only, never on the inputs
   // ---------------------------------------------------------------------
   assign t_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOADED) ||
                    (state_reg == ST_DONE);
   assign load      = t_valid & t_ready;
   assign load_zero = (t_in == '0);

   // ---------------------------------------------------------------------
   // Next-state / counter logic
   // abort beats everything (including a load offered in the same cycle),
   // then pause, then start.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      elapsed_next   = elapsed_reg;
      done_evt       = 1'b0;
      presc_clr      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!abort && load) begin
               remaining_next = t_in;
               elapsed_next   = '0;
               state_next     = load_zero ? ST_DONE : ST_LOADED;
               done_evt       = load_zero;
            end
         end

         ST_LOADED: begin
            if (abort) begin
               state_next     = ST_IDLE;
               remaining_next = '0;
               elapsed_next   = '0;
            end else if (load) begin
               // A reload replaces the pending T; a start in the same
               // cycle is ignored.
               remaining_next = t_in;
               elapsed_next   = '0;
               state_next     = load_zero ? ST_DONE : ST_LOADED;
               done_evt       = load_zero;
            end else if (!pause && start) begin
               state_next = ST_RUN;
               presc_clr  = 1'b1;
            end
         end

         ST_RUN: begin
            if (abort) begin
               state_next     = ST_IDLE;
               remaining_next = '0;
               elapsed_next   = '0;
            end else begin
               // A tick coinciding with pause still counts; reaching zero
               // takes precedence over entering PAUSE.
               if (tick && (remaining_reg != '0)) begin
                  remaining_next = remaining_reg - 1'b1;
                  elapsed_next   = elapsed_reg + 1'b1;
               end
               if (tick && (remaining_reg == TW'(1))) begin
                  state_next = ST_DONE;
                  done_evt   = 1'b1;
               end else if (pause) begin
                  state_next = ST_PAUSE;
               end
            end
         end

         ST_PAUSE: begin
            if (abort) begin
               state_next     = ST_IDLE;
               remaining_next = '0;
               elapsed_next   = '0;
            end else if (!pause && start) begin
               // Prescaler is not cleared: the partial minute carries over.
               state_next = ST_RUN;
            end
         end

         ST_DONE: begin
            if (abort) begin
               state_next     = ST_IDLE;
               remaining_next = '0;
               elapsed_next   = '0;
            end else if (load) begin
               remaining_next = t_in;
               elapsed_next   = '0;
               state_next     = load_zero ? ST_DONE : ST_LOADED;
               done_evt       = load_zero;
            end
         end

         default: begin
            state_next     = ST_IDLE;
            remaining_next = '0;
            elapsed_next   = '0;
         end
      endcase
   end

   // Suppressing the pulse when done is already high keeps it strictly one
   // cycle wide, even if a zero T is reloaded right after completion.
   assign done_next   = done_evt & ~done_reg;
   assign busy_next   = (state_next == ST_RUN) || (state_next == ST_PAUSE);
   assign paused_next = (state_next == ST_PAUSE);

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= ST_IDLE;
         remaining_reg <= '0;
         elapsed_reg   <= '0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         paused_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         elapsed_reg   <= elapsed_next;
         done_reg      <= done_next;
         busy_reg      <= busy_next;
         paused_reg    <= paused_next;
      end
   end

   assign remaining = remaining_reg;
   assign elapsed   = elapsed_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;
   assign paused    = paused_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_t_timer.sv
// tb_t_timer
//    Directed scenarios plus a randomized run of t_timer (TICKS_PER_UNIT=4)
//    checked against a session-level model: a session is described by its
//    T and the number of cycles spent running, from which remaining and
//    elapsed follow by division.
module tb_t_timer;

   localparam int K  = 4;
   localparam int TW = 9;

   localparam int M_IDLE   = 0;
   localparam int M_LOADED = 1;
   localparam int M_RUN    = 2;
   localparam int M_PAUSE  = 3;
   localparam int M_DONE   = 4;

   logic          clk;
   logic          rstn;
   logic [TW-1:0] t_in;
   logic          t_valid;
   logic          t_ready;
   logic          start;
   logic          pause;
   logic          abort;
   logic [TW-1:0] remaining;
   logic [TW-1:0] elapsed;
   logic          busy;
   logic          paused;
   logic          done;
   logic [2:0]    state;

   int tests = 0;
   int fails = 0;

   // session model
   int m_phase;
   int m_t;
   int m_rc;
   bit m_done;

   t_timer #(
      .TICKS_PER_UNIT (K),
      .TW             (TW)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .t_in      (t_in),
      .t_valid   (t_valid),
      .t_ready   (t_ready),
      .start     (start),
      .pause     (pause),
      .abort     (abort),
      .remaining (remaining),
      .elapsed   (elapsed),
      .busy      (busy),
      .paused    (paused),
      .done      (done),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   task automatic model_reset();
      m_phase = M_IDLE;
      m_t     = 0;
      m_rc    = 0;
      m_done  = 1'b0;
   endtask

   task automatic model_load(inout bit ev);
      m_t  = int'(t_in);
      m_rc = 0;
      if (m_t == 0) begin
         m_phase = M_DONE;
         ev      = 1'b1;
      end else begin
         m_phase = M_LOADED;
      end
   endtask

   task automatic model_cancel();
      m_phase = M_IDLE;
      m_t     = 0;
      m_rc    = 0;
   endtask

   task automatic model_step();
      bit ready;
      bit ld;
      bit ev;
      ev    = 1'b0;
      ready = (m_phase == M_IDLE) || (m_phase == M_LOADED) || (m_phase == M_DONE);
      ld    = t_valid && ready;
      if (!rstn) begin
         model_reset();
         return;
      end
      case (m_phase)
         M_IDLE:   if (!abort && ld) model_load(ev);
         M_LOADED: begin
            if (abort) model_cancel();
            else if (ld) model_load(ev);
            else if (start && !pause) begin
               m_phase = M_RUN;
               m_rc    = 0;
            end
         end
         M_RUN: begin
            if (abort) model_cancel();
            else begin
               m_rc++;
               if (m_rc == m_t * K) begin
                  m_phase = M_DONE;
                  ev      = 1'b1;
               end else if (pause) begin
                  m_phase = M_PAUSE;
               end
            end
         end
         M_PAUSE: begin
            if (abort) model_cancel();
            else if (!pause && start) m_phase = M_RUN;
         end
         default: begin
            if (abort) model_cancel();
            else if (ld) model_load(ev);
         end
      endcase
      m_done = ev && !m_done;
   endtask

   function automatic logic [TW-1:0] exp_rem();
      return TW'(m_t - m_rc / K);
   endfunction

   function automatic logic [TW-1:0] exp_el();
      return TW'(m_rc / K);
   endfunction

   // One clock: advance the model at the edge, return at the falling edge
   // where outputs are sampled and new inputs are driven.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      t_valid = 1'b0;
      t_in    = '0;
      start   = 1'b0;
      pause   = 1'b0;
      abort   = 1'b0;
   endtask

   // Return to IDLE with done low before a new scenario.
   task automatic settle();
      idle_inputs();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      cycle();
   endtask

   task automatic load_and_start(input int t);
      t_in    = TW'(t);
      t_valid = 1'b1;
      cycle();
      t_valid = 1'b0;
      start   = 1'b1;
      cycle();
      start   = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      cycle();
      cycle();
      tests++;
      if (state !== 3'd0 || remaining !== '0 || elapsed !== '0 || busy !== 1'b0 ||
          paused !== 1'b0 || done !== 1'b0 || t_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_values state=%0d rem=%0d el=%0d busy=%b paused=%b done=%b ready=%b expected 0/0/0/0/0/0/1",
                  state, remaining, elapsed, busy, paused, done, t_ready);
      end
      rstn = 1'b1;
      cycle();
      $display("[TB] reset checked");
   endtask

   task automatic test_basic();
      int pulses;
      pulses = 0;
      settle();
      t_in = 9'd3; t_valid = 1'b1;
      cycle();
      t_valid = 1'b0;
      tests++;
      if (state !== 3'd1 || remaining !== 9'd3 || elapsed !== 9'd0) begin
         fails++;
         $display("FAIL basic_load state=%0d rem=%0d el=%0d expected 1/3/0", state, remaining, elapsed);
      end
      start = 1'b1;
      cycle();
      start = 1'b0;
      tests++;
      if (state !== 3'd2 || busy !== 1'b1 || remaining !== 9'd3) begin
         fails++;
         $display("FAIL basic_start state=%0d busy=%b rem=%0d expected 2/1/3", state, busy, remaining);
      end
      for (int i = 1; i <= 12; i++) begin
         cycle();
         if (done === 1'b1) pulses++;
         tests++;
         if (remaining !== TW'(3 - i / 4) || elapsed !== TW'(i / 4) ||
             done !== (i == 12)) begin
            fails++;
            $display("FAIL basic_count cyc=%0d rem=%0d el=%0d done=%b expected %0d/%0d/%b",
                     i, remaining, elapsed, done, 3 - i / 4, i / 4, (i == 12));
         end
      end
      tests++;
      if (pulses != 1 || state !== 3'd4 || elapsed !== 9'd3 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_end pulses=%0d state=%0d el=%0d busy=%b expected 1/4/3/0",
                  pulses, state, elapsed, busy);
      end
      cycle();
      tests++;
      if (done !== 1'b0 || state !== 3'd4 || remaining !== 9'd0) begin
         fails++;
         $display("FAIL basic_done_width done=%b state=%0d rem=%0d expected 0/4/0", done, state, remaining);
      end
      $display("[TB] basic T=3 session checked");
   endtask

   task automatic test_zero();
      settle();
      t_in = 9'd0; t_valid = 1'b1;
      cycle();
      t_valid = 1'b0;
      tests++;
      if (state !== 3'd4 || done !== 1'b1 || remaining !== 9'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL zero_load state=%0d done=%b rem=%0d busy=%b expected 4/1/0/0", state, done, remaining, busy);
      end
      cycle();
      tests++;
      if (state !== 3'd4 || done !== 1'b0) begin
         fails++;
         $display("FAIL zero_after state=%0d done=%b expected 4/0", state, done);
      end
      $display("[TB] zero T checked");
   endtask

   task automatic test_pause();
      int n;
      bit hit;
      settle();
      load_and_start(5);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n++;
      end
      pause = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         cycle();
         n++;
         tests++;
         if (state !== 3'd3 || paused !== 1'b1 || remaining !== 9'd4 || elapsed !== 9'd1) begin
            fails++;
            $display("FAIL pause_hold j=%0d state=%0d paused=%b rem=%0d el=%0d expected 3/1/4/1",
                     j, state, paused, remaining, elapsed);
         end
      end
      pause = 1'b0;
      start = 1'b1;
      cycle();
      n++;
      start = 1'b0;
      tests++;
      if (state !== 3'd2 || paused !== 1'b0) begin
         fails++;
         $display("FAIL pause_resume state=%0d paused=%b expected 2/0", state, paused);
      end
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         cycle();
         n++;
         if (state === 3'd4) hit = 1'b1;
      end
      tests++;
      if (!hit || n != 5 * K + 10 || done !== 1'b1 || elapsed !== 9'd5) begin
         fails++;
         $display("FAIL pause_total reached=%b cycles=%0d done=%b el=%0d expected 1/%0d/1/5",
                  hit, n, done, elapsed, 5 * K + 10);
      end
      $display("[TB] pause/resume session checked");
   endtask

   task automatic test_abort();
      settle();
      load_and_start(2);
      for (int i = 0; i < 7; i++) cycle();
      tests++;
      if (state !== 3'd2 || remaining !== 9'd1) begin
         fails++;
         $display("FAIL abort_pre state=%0d rem=%0d expected 2/1", state, remaining);
      end
      abort = 1'b1;
      pause = 1'b1;
      cycle();
      abort = 1'b0;
      pause = 1'b0;
      tests++;
      if (state !== 3'd0 || remaining !== 9'd0 || elapsed !== 9'd0 || done !== 1'b0 ||
          busy !== 1'b0 || paused !== 1'b0) begin
         fails++;
         $display("FAIL abort_tick state=%0d rem=%0d el=%0d done=%b busy=%b paused=%b expected 0/0/0/0/0/0",
                  state, remaining, elapsed, done, busy, paused);
      end
      cycle();
      tests++;
      if (done !== 1'b0 || state !== 3'd0) begin
         fails++;
         $display("FAIL abort_after done=%b state=%0d expected 0/0", done, state);
      end
      $display("[TB] abort on tick checked");
   endtask

   task automatic test_busy_load();
      bit hit;
      settle();
      load_and_start(1);
      t_in = 9'd7; t_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         tests++;
         if (t_ready !== 1'b0 || state !== 3'd2 || remaining !== 9'd1) begin
            fails++;
            $display("FAIL busy_run ready=%b state=%0d rem=%0d expected 0/2/1", t_ready, state, remaining);
         end
      end
      pause = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      tests++;
      if (t_ready !== 1'b0 || state !== 3'd3 || remaining !== 9'd1) begin
         fails++;
         $display("FAIL busy_pause ready=%b state=%0d rem=%0d expected 0/3/1", t_ready, state, remaining);
      end
      pause = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         cycle();
         if (state === 3'd4) hit = 1'b1;
      end
      tests++;
      if (!hit || t_ready !== 1'b1 || remaining !== 9'd0) begin
         fails++;
         $display("FAIL busy_done reached=%b ready=%b rem=%0d expected 1/1/0", hit, t_ready, remaining);
      end
      cycle();
      t_valid = 1'b0;
      tests++;
      if (state !== 3'd1 || remaining !== 9'd7 || elapsed !== 9'd0) begin
         fails++;
         $display("FAIL busy_reload state=%0d rem=%0d el=%0d expected 1/7/0", state, remaining, elapsed);
      end
      $display("[TB] load blocked while busy checked");
   endtask

   task automatic test_async_reset();
      settle();
      load_and_start(4);
      for (int i = 0; i < 5; i++) cycle();
      #2;
      rstn = 1'b0;
      #1;
      tests++;
      if (state !== 3'd0 || remaining !== '0 || elapsed !== '0 || busy !== 1'b0 ||
          paused !== 1'b0 || done !== 1'b0 || t_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_reset state=%0d rem=%0d el=%0d busy=%b paused=%b done=%b ready=%b expected 0/0/0/0/0/0/1",
                  state, remaining, elapsed, busy, paused, done, t_ready);
      end
      model_reset();
      cycle();
      rstn = 1'b1;
      cycle();
      t_in = 9'd2; t_valid = 1'b1;
      cycle();
      t_valid = 1'b0;
      tests++;
      if (state !== 3'd1 || remaining !== 9'd2) begin
         fails++;
         $display("FAIL async_reload state=%0d rem=%0d expected 1/2", state, remaining);
      end
      $display("[TB] asynchronous reset checked");
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      settle();
      for (int i = 0; i < 600; i++) begin
         t_valid = ($urandom_range(0, 3) == 0);
         t_in    = TW'($urandom_range(0, 6));
         start   = ($urandom_range(0, 1) == 1);
         pause   = ($urandom_range(0, 5) == 0);
         abort   = ($urandom_range(0, 40) == 0);
         cycle();
         tests++;
         if (state !== 3'(m_phase) || remaining !== exp_rem() || elapsed !== exp_el() ||
             done !== m_done || busy !== (m_phase == M_RUN || m_phase == M_PAUSE) ||
             paused !== (m_phase == M_PAUSE) ||
             t_ready !== (m_phase == M_IDLE || m_phase == M_LOADED || m_phase == M_DONE)) begin
            fails++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cyc=%0d state=%0d rem=%0d el=%0d done=%b busy=%b paused=%b ready=%b expected %0d/%0d/%0d/%b",
                        i, state, remaining, elapsed, done, busy, paused, t_ready,
                        m_phase, exp_rem(), exp_el(), m_done);
         end
      end
      idle_inputs();
      $display("[TB] randomized run of 600 cycles checked");
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_basic();
      test_zero();
      test_pause();
      test_abort();
      test_busy_load();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
